// File: rtl/uart_tx_fifo.sv
// UART transmitter with a built-in transmit FIFO and compile-time frame format
// (5..9 data bits, none/odd/even parity, 1 or 2 stop bits), LSB-first on tx_pin.
module uart_tx_fifo #(
  parameter int unsigned CLK_FRE    = 27,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned STOP_LEN = STOP_BITS * CYCLE;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);

  // Reject frame formats and clocking the datapath cannot represent.
  if (CYCLE < 2) begin : g_bad_cycle
    $error("uart_tx_fifo: CLK_FRE/BAUD_RATE gives fewer than 2 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_busy_q, tx_busy_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_data_ready = rst_n && (count_q != CNT_W'(FIFO_DEPTH));
  assign tx_pin        = tx_pin_q;
  assign tx_busy       = tx_busy_q;
  assign fifo_count    = count_q;

  // Next-state, FIFO bookkeeping and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_pin_d   = tx_pin_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    pop        = 1'b0;
    push       = tx_data_valid && tx_data_ready;
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];

    case (state_q)
      S_IDLE: begin
        tx_pin_d = 1'b1;
        cnt_d    = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_d  = S_START;
          tx_pin_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == 32'(CYCLE - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
          tx_pin_d  = shift_q[0];
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 32'(CYCLE - 1)) begin
          cnt_d = '0;
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              tx_pin_d = parity_q;
            end else begin
              state_d  = S_STOP;
              tx_pin_d = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_pin_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == 32'(CYCLE - 1)) begin
          cnt_d    = '0;
          state_d  = S_STOP;
          tx_pin_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STOP: begin
        // Last stop clock chains straight into the next start bit when data waits.
        if (cnt_q == 32'(STOP_LEN - 1)) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_d  = S_START;
            tx_pin_d = 1'b0;
          end else begin
            state_d  = S_IDLE;
            tx_pin_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tx_pin_d = 1'b1;
        cnt_d    = '0;
      end
    endcase

    if (pop) begin
      shift_d   = head;
      parity_d  = (PARITY == 1) ? ~(^head) : (^head);
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      bit_idx_d = '0;
      cnt_d     = '0;
    end

    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    tx_busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset flushes the FIFO by clearing pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_pin_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_pin_q  <= tx_pin_d;
      tx_busy_q <= tx_busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four frame formats at 4 clocks per bit,
// table-driven single-frame vectors plus full-FIFO and mid-frame reset sequences.
module tb_uart_tx_fifo;

  localparam int unsigned NCFG = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      d8    = '0;
  logic [NCFG-1:0] vld   = '0;
  logic [NCFG-1:0] rdy;
  logic [NCFG-1:0] pin;
  logic [NCFG-1:0] busy;
  logic [2:0]      cnt [NCFG];

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int         cfg;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] words [5];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_data_valid(vld[0]),
    .tx_data_ready(rdy[0]), .tx_pin(pin[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_8e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_data_valid(vld[1]),
    .tx_data_ready(rdy[1]), .tx_pin(pin[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_data_valid(vld[2]),
    .tx_data_ready(rdy[2]), .tx_pin(pin[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(250000), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8[6:0]), .tx_data_valid(vld[3]),
    .tx_data_ready(rdy[3]), .tx_pin(pin[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one word at edge k, then follow the frame clock by clock.
  task automatic run_vec(input int i);
    int          c;
    logic [11:0] fr;
    c  = vecs[i].cfg;
    fr = vecs[i].frame;
    d8 = vecs[i].data;
    vld[c] = 1'b1;
    tick();
    vld[c] = 1'b0;
    check($sformatf("v%0d count_after_push", i), 32'(cnt[c]), 32'd1);
    check($sformatf("v%0d pin_at_push", i), 32'(pin[c]), 32'd1);
    for (int b = 0; b < vecs[i].nbits; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        check($sformatf("v%0d bit%0d clk%0d busy_pin", i, b, k),
              32'({busy[c], pin[c]}), 32'({1'b1, fr[b]}));
      end
    end
    tick();
    check($sformatf("v%0d end busy_pin_count", i),
          32'({busy[c], pin[c], cnt[c]}), 32'({1'b0, 1'b1, 3'd0}));
  endtask

  initial begin
    // Frame bits in transmit order: bit0 = start, then data LSB-first, parity, stop(s).
    vecs[0] = '{0, 8'h55, 12'h2AA, 10};
    vecs[1] = '{1, 8'h07, 12'hE0E, 12};
    vecs[2] = '{2, 8'h07, 12'h40E, 11};
    vecs[3] = '{1, 8'h00, 12'hC00, 12};
    vecs[4] = '{3, 8'h7F, 12'h1FE, 9};
    vecs[5] = '{0, 8'hA5, 12'h34A, 10};
    vecs[6] = '{2, 8'hFF, 12'h7FE, 11};
    vecs[7] = '{1, 8'h01, 12'hE02, 12};
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset held for 3 clocks, then released.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int c = 0; c < NCFG; c++)
        check($sformatf("reset%0d cfg%0d pin_busy_cnt_rdy", i, c),
              32'({pin[c], busy[c], cnt[c], rdy[c]}), 32'h20);
    end
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < NCFG; c++)
      check($sformatf("release cfg%0d pin_busy_cnt_rdy", c),
            32'({pin[c], busy[c], cnt[c], rdy[c]}), 32'h21);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Full FIFO with back-to-back frames on the 8N1 instance.
    d8     = words[0];
    vld[0] = 1'b1;
    tick();
    fork
      begin
        logic acc;
        int   guard;
        for (int w = 1; w < 5; w++) begin
          d8    = words[w];
          acc   = 1'b0;
          guard = 0;
          while (!acc && guard < 100) begin
            acc = rdy[0];
            tick();
            guard++;
          end
          check($sformatf("full accept word%0d", w), 32'(acc), 32'd1);
        end
        check("full count", 32'(cnt[0]), 32'd4);
        check("full ready", 32'(rdy[0]), 32'd0);
        d8 = 8'h66;
        for (int k = 0; k < 2; k++) begin
          tick();
          check($sformatf("full hold%0d count", k), 32'(cnt[0]), 32'd4);
          check($sformatf("full hold%0d ready", k), 32'(rdy[0]), 32'd0);
        end
        vld[0] = 1'b0;
      end
      begin
        logic [9:0] fb;
        for (int t = 0; t < 200; t++) begin
          tick();
          fb = {1'b1, words[t / 40], 1'b0};
          check($sformatf("b2b t%0d busy_pin", t),
                32'({busy[0], pin[0]}), 32'({1'b1, fb[(t % 40) / 4]}));
        end
        tick();
        check("b2b end busy_pin_count",
              32'({busy[0], pin[0], cnt[0]}), 32'({1'b0, 1'b1, 3'd0}));
      end
    join

    // Reset during data bit 3 of 0xA5 with two words queued.
    d8     = 8'hA5;
    vld[0] = 1'b1;
    tick();
    d8 = 8'h01;
    tick();
    d8 = 8'h02;
    tick();
    vld[0] = 1'b0;
    repeat (16) tick();
    check("midrst before busy_pin_count",
          32'({busy[0], pin[0], cnt[0]}), 32'({1'b1, 1'b0, 3'd2}));
    rst_n = 1'b0;
    tick();
    check("midrst pin_busy_cnt_rdy", 32'({pin[0], busy[0], cnt[0], rdy[0]}), 32'h20);
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      check($sformatf("midrst after t%0d busy_pin_count", t),
            32'({busy[0], pin[0], cnt[0]}), 32'({1'b0, 1'b1, 3'd0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
